// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: memory freeze > redirect flush > load-use.
// Optional HAZARD_PERF_CNT_EN adds stall/flush/memory-wait counters.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic             use_rs1D,
   input  logic             use_rs2D,
   input  logic [4:0]       rdE,
   input  logic [2:0]       mem_loadE,
   input  logic             reg_writeE,
   input  logic             fail_predictE,
   input  logic             memopM,
   input  logic             dmem_busy,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             bubbleE,
   output logic             stallE,
   output logic             stallM,
   output logic             bubbleW,
   output logic [1:0]       stateQ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] memwait_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      REDIR = 2'd1,
      MEMW  = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

   state_t     state_q, state_d, eff;
   logic [2:0] cnt_q, cnt_d;
   logic       mw, lu;

   assign mw = memopM & dmem_busy;
   assign lu = (mem_loadE != 3'd0) & reg_writeE & (rdE != 5'd0) &
               ((use_rs1D & (rs1D == rdE)) | (use_rs2D & (rs2D == rdE)));
   assign stateQ = state_q;

   // leaving MEMW resumes whatever sequence the freeze interrupted
   always_comb begin
      eff = RUN;
      case (state_q)
         REDIR:   eff = REDIR;
         MEMW:    eff = (cnt_q != 3'd0) ? REDIR : RUN;
         default: eff = RUN;
      endcase
   end

   always_comb begin
      stallF  = 1'b0;
      stallD  = 1'b0;
      flushD  = 1'b0;
      bubbleE = 1'b0;
      stallE  = 1'b0;
      stallM  = 1'b0;
      bubbleW = 1'b0;
      state_d = eff;
      cnt_d   = cnt_q;
      if (RST) begin
         flushD  = 1'b1;
         bubbleE = 1'b1;
         bubbleW = 1'b1;
         state_d = RUN;
         cnt_d   = 3'd0;
      end else if (mw) begin
         stallF  = 1'b1;
         stallD  = 1'b1;
         stallE  = 1'b1;
         stallM  = 1'b1;
         bubbleW = 1'b1;
         state_d = MEMW;
      end else if (fail_predictE) begin
         flushD  = 1'b1;
         bubbleE = 1'b1;
         cnt_d   = FLUSH_LD;
         state_d = (FLUSH_LD != 3'd0) ? REDIR : RUN;
      end else if (eff == REDIR) begin
         flushD  = 1'b1;
         bubbleE = 1'b1;
         if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = RUN;
         end else begin
            cnt_d   = cnt_q - 3'd1;
            state_d = REDIR;
         end
      end else if (lu) begin
         stallF  = 1'b1;
         stallD  = 1'b1;
         bubbleE = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic fp_win, lu_win;

   assign fp_win = ~mw & fail_predictE;
   assign lu_win = ~mw & ~fail_predictE & (eff == RUN) & lu;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         memwait_cnt <= '0;
      end else begin
         if (lu_win) stall_cnt <= stall_cnt + CNT_W'(1);
         if (fp_win) flush_cnt <= flush_cnt + CNT_W'(1);
         if (mw) memwait_cnt <= memwait_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt   = '0;
   assign flush_cnt   = '0;
   assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors, FLUSH_CYCLES=2.
module tb_hazard_ctrl;

   localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [4:0]       rs1D = '0, rs2D = '0, rdE = '0;
   logic             use_rs1D = 1'b0, use_rs2D = 1'b0;
   logic [2:0]       mem_loadE = '0;
   logic             reg_writeE = 1'b0, fail_predictE = 1'b0;
   logic             memopM = 1'b0, dmem_busy = 1'b0;
   logic             stallF, stallD, flushD, bubbleE;
   logic             stallE, stallM, bubbleW;
   logic [1:0]       stateQ;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;

   hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .rs1D(rs1D), .rs2D(rs2D),
      .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
      .rdE(rdE), .mem_loadE(mem_loadE),
      .reg_writeE(reg_writeE), .fail_predictE(fail_predictE),
      .memopM(memopM), .dmem_busy(dmem_busy),
      .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .bubbleE(bubbleE), .stallE(stallE), .stallM(stallM),
      .bubbleW(bubbleW), .stateQ(stateQ),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .memwait_cnt(memwait_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2;
      logic [2:0] ml;
      logic       rw, fp, mo, busy;
      logic [6:0] outs;
      logic [1:0] st;
      int         sc, fc, mc;
   } vec_t;

   typedef struct {
      int         idx;
      logic [6:0] outs;
      logic [1:0] st;
      int         sc, fc, mc;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   popped = 0;

   // outs = {stallF,stallD,flushD,bubbleE,stallE,stallM,bubbleW}
   localparam logic [6:0] O_IDLE = 7'b0000000;
   localparam logic [6:0] O_LU   = 7'b1101000;
   localparam logic [6:0] O_FL   = 7'b0011000;
   localparam logic [6:0] O_MW   = 7'b1100111;
   localparam logic [6:0] O_RST  = 7'b0011001;

   function automatic vec_t mk(
      logic rst, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
      logic [4:0] rd, logic [2:0] ml, logic rw, logic fp, logic mo,
      logic busy, logic [6:0] outs, logic [1:0] st,
      int sc, int fc, int mc);
      vec_t v;
      v.rst = rst; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.rd = rd; v.ml = ml; v.rw = rw; v.fp = fp; v.mo = mo;
      v.busy = busy; v.outs = outs; v.st = st;
      v.sc = sc; v.fc = fc; v.mc = mc;
      return v;
   endfunction

   task automatic check(string name, int idx, longint act, longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s v%0d: got %0h want %0h", name, idx, act, req);
      end
   endtask

   // monitor: DUT presents combinational outputs every cycle
   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [6:0] o;
         e = sb.pop_front();
         popped++;
         o = {stallF, stallD, flushD, bubbleE, stallE, stallM, bubbleW};
         check("outs", e.idx, longint'(o), longint'(e.outs));
         check("stateQ", e.idx, longint'(stateQ), longint'(e.st));
         check("stallD_flushD_excl", e.idx,
               longint'(stallD & flushD), 0);
         check("stall_cnt", e.idx, longint'(stall_cnt),
               PERF ? longint'(e.sc) : 0);
         check("flush_cnt", e.idx, longint'(flush_cnt),
               PERF ? longint'(e.fc) : 0);
         check("memwait_cnt", e.idx, longint'(memwait_cnt),
               PERF ? longint'(e.mc) : 0);
      end
   end

   initial begin
      //         rst rs1 u1 rs2 u2 rd ml rw fp mo bz outs   st sc fc mc
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0, 0));
      vq.push_back(mk(0, 5, 1, 1, 0, 5, 2, 1, 0, 0, 0, O_LU, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 1, 0, 0, 0, 2, 1, 0, 0, 0, O_IDLE, 0, 1, 0, 0));
      vq.push_back(mk(0, 1, 0, 7, 0, 7, 2, 1, 0, 0, 0, O_IDLE, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FL, 0, 1, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL, 1, 1, 1, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_MW, 1, 1, 1, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_MW, 2, 1, 1, 1));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_MW, 2, 1, 1, 2));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL, 2, 1, 1, 3));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 1, 1, 3));
      vq.push_back(mk(0, 5, 1, 0, 0, 5, 2, 1, 1, 0, 0, O_FL, 0, 1, 1, 3));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL, 1, 1, 2, 3));
      vq.push_back(mk(0, 5, 1, 0, 0, 5, 2, 1, 0, 0, 0, O_FL, 1, 1, 2, 3));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 1, 2, 3));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_MW, 0, 1, 2, 3));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_MW, 2, 1, 2, 4));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FL, 2, 1, 2, 5));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL, 1, 1, 3, 5));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_MW, 1, 1, 3, 5));
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_RST, 2, 1, 3, 6));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_MW, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 9, 1, 9, 4, 1, 0, 0, 0, O_LU, 2, 0, 0, 1));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 1, 0, 1));

      repeat (2) @(posedge CLK);
      foreach (vq[i]) begin
         exp_t e;
         #1;
         RST = vq[i].rst;
         rs1D = vq[i].rs1; use_rs1D = vq[i].u1;
         rs2D = vq[i].rs2; use_rs2D = vq[i].u2;
         rdE = vq[i].rd; mem_loadE = vq[i].ml;
         reg_writeE = vq[i].rw; fail_predictE = vq[i].fp;
         memopM = vq[i].mo; dmem_busy = vq[i].busy;
         e.idx = i; e.outs = vq[i].outs; e.st = vq[i].st;
         e.sc = vq[i].sc; e.fc = vq[i].fc; e.mc = vq[i].mc;
         sb.push_back(e);
         @(posedge CLK);
      end
      repeat (3) @(posedge CLK);
      checks++;
      if (sb.size() != 0 || popped != vq.size()) begin
         errors++;
         $display("FAIL scoreboard_drain: popped %0d want %0d",
                  popped, vq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
